// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One shared shift-add / restoring-subtract datapath, N_BITS iterations.
module muldiv_seq #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic [2:0]        req_op,
    input  logic [N_BITS-1:0] op1,
    input  logic [N_BITS-1:0] op2,
    input  logic              squash_in,
    output logic              stall_req,
    output logic              res_vld,
    output logic [N_BITS-1:0] result
);

    localparam int CW = $clog2(N_BITS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]     LAST    = CW'(N_BITS - 1);
    localparam logic [N_BITS-1:0] INT_MIN = {1'b1, {(N_BITS-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [N_BITS-1:0] mag1;
    logic [N_BITS-1:0] mag2;
    logic              neg1;
    logic              neg2;
    logic              raw_q;
    logic [N_BITS-1:0] hi;
    logic [N_BITS-1:0] lo;
    logic [N_BITS-1:0] result_q;

    logic              accept;
    logic              is_div;
    logic              sgn1;
    logic              sgn2;
    logic              s1;
    logic              s2;
    logic [N_BITS-1:0] a1;
    logic [N_BITS-1:0] a2;
    logic              div_zero;
    logic              div_ovf;

    logic [N_BITS:0]   mul_sum;
    logic [N_BITS-1:0] rem_sh;
    logic [N_BITS-1:0] dif;
    logic              bw;
    logic              take;
    logic [N_BITS-1:0] nxt_hi;
    logic [N_BITS-1:0] nxt_lo;

    logic [2*N_BITS-1:0] prod_f;
    logic [N_BITS-1:0]   quo_f;
    logic [N_BITS-1:0]   rem_f;
    logic [N_BITS-1:0]   res_fix;

    // Request decode: signedness, magnitudes and divide corner cases
    always_comb begin
        accept   = (state == S_IDLE) && req_vld && !squash_in;
        is_div   = req_op[2];
        sgn1     = (req_op == 3'b001) || (req_op == 3'b010) ||
                   (req_op == 3'b100) || (req_op == 3'b110);
        sgn2     = (req_op == 3'b001) || (req_op == 3'b100) ||
                   (req_op == 3'b110);
        s1       = sgn1 && op1[N_BITS-1];
        s2       = sgn2 && op2[N_BITS-1];
        a1       = s1 ? -op1 : op1;
        a2       = s2 ? -op2 : op2;
        div_zero = is_div && (op2 == '0);
        div_ovf  = is_div && !req_op[0] &&
                   (op1 == INT_MIN) && (&op2);
    end

    // One datapath iteration: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag1} : '0);
        rem_sh    = {hi[N_BITS-2:0], lo[N_BITS-1]};
        {bw, dif} = {1'b0, rem_sh} - {1'b0, mag2};
        // a set top bit means the shifted remainder exceeds any divisor
        take      = hi[N_BITS-1] || !bw;
        if (op_q[2]) begin
            nxt_hi = take ? dif : rem_sh;
            nxt_lo = {lo[N_BITS-2:0], take};
        end else begin
            nxt_hi = mul_sum[N_BITS:1];
            nxt_lo = {mul_sum[0], lo[N_BITS-1:1]};
        end
    end

    // Sign fix and result select from registered state
    always_comb begin
        prod_f = (neg1 ^ neg2) ? -{hi, lo} : {hi, lo};
        quo_f  = (!raw_q && (neg1 ^ neg2)) ? -lo : lo;
        rem_f  = (!raw_q && neg1) ? -hi : hi;
        case (op_q)
            3'b000:  res_fix = prod_f[N_BITS-1:0];
            3'b001,
            3'b010,
            3'b011:  res_fix = prod_f[2*N_BITS-1:N_BITS];
            3'b100,
            3'b101:  res_fix = quo_f;
            default: res_fix = rem_f;
        endcase
    end

    // Handshake outputs; result holds between valid cycles
    always_comb begin
        stall_req = accept || (state == S_BUSY);
        res_vld   = (state == S_DONE) && !squash_in;
        result    = res_vld ? res_fix : result_q;
    end

    // Sequencer FSM and operand/accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            mag1     <= '0;
            mag2     <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            raw_q    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= req_op;
                        mag1 <= a1;
                        mag2 <= a2;
                        neg1 <= s1;
                        neg2 <= s2;
                        cnt  <= '0;
                        if (div_zero) begin
                            hi    <= op1;
                            lo    <= '1;
                            raw_q <= 1'b1;
                            state <= S_DONE;
                        end else if (div_ovf) begin
                            hi    <= '0;
                            lo    <= op1;
                            raw_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= is_div ? a1 : a2;
                            raw_q <= 1'b0;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (squash_in) begin
                        state <= S_IDLE;
                    end else begin
                        hi  <= nxt_hi;
                        lo  <= nxt_lo;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!squash_in) begin
                        result_q <= res_fix;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: latency, results, corner cases,
// squash and reset behaviour.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic [2:0]  req_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        squash_in;
    logic        stall_req;
    logic        res_vld;
    logic [31:0] result;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    muldiv_seq #(.N_BITS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_op    (req_op),
        .op1       (op1),
        .op2       (op2),
        .squash_in (squash_in),
        .stall_req (stall_req),
        .res_vld   (res_vld),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        int          q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        model = '0;
        case (op)
            3'd0: begin p = 64'(ua * ub); model = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); model = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); model = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); model = p[63:32]; end
            3'd4: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = a;
                else begin q = $signed(a) / $signed(b); model = q; end
            end
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = 32'h0;
                else begin q = $signed(a) % $signed(b); model = q; end
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every valid result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && res_vld) begin
            if (exp_q.size() == 0) begin
                check("spurious_vld", 32'd1, 32'd0);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input int stl);
        int n;
        int s;
        bit seen;
        logic [31:0] e;
        @(posedge clk); #1;
        req_vld = 1'b1;
        req_op  = op;
        op1     = a;
        op2     = b;
        e       = model(op, a, b);
        exp_q.push_back(e);
        @(negedge clk);
        check("stall_idle", {31'b0, stall_req}, 32'd1);
        @(posedge clk); #1;
        op1 = $urandom;
        op2 = $urandom;
        n = 0;
        s = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (res_vld) seen = 1'b1;
            else if (stall_req) s++;
        end
        req_vld = 1'b0;
        check("latency", 32'(n), 32'(lat));
        check("stall_cnt", 32'(s), 32'(stl));
        @(negedge clk);
        check("post_stall", {31'b0, stall_req}, 32'd0);
        check("post_vld", {31'b0, res_vld}, 32'd0);
        check("hold", result, e);
        last_res = e;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_res  = '0;
        rst_n     = 1'b0;
        req_vld   = 1'b0;
        req_op    = '0;
        op1       = '0;
        op2       = '0;
        squash_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'b0, stall_req}, 32'd0);
        check("rst_vld", {31'b0, res_vld}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 33, 32);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 33, 32);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 33, 32);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 33, 32);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 33, 32);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 33, 32);
        run_op(3'd5, 32'd100, 32'd7, 33, 32);
        run_op(3'd7, 32'd100, 32'd7, 33, 32);
        run_op(3'd5, 32'd5, 32'd0, 1, 0);
        run_op(3'd6, 32'd5, 32'd0, 1, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 33, 32);
        run_op(3'd6, 32'h8765_4321, 32'h0000_1234, 33, 32);

        // Squash a divide at iteration 10
        @(posedge clk); #1;
        req_vld = 1'b1;
        req_op  = 3'd4;
        op1     = 32'd1000;
        op2     = 32'd3;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        squash_in = 1'b1;
        req_vld   = 1'b0;
        @(posedge clk); #1;
        squash_in = 1'b0;
        @(negedge clk);
        check("sq_stall", {31'b0, stall_req}, 32'd0);
        repeat (40) @(negedge clk);
        check("sq_hold", result, last_res);
        run_op(3'd0, 32'd3, 32'd4, 33, 32);

        // Squash in DONE suppresses the valid and keeps the old result
        @(posedge clk); #1;
        req_vld = 1'b1;
        req_op  = 3'd5;
        op1     = 32'd5;
        op2     = 32'd0;
        @(posedge clk); #1;
        squash_in = 1'b1;
        req_vld   = 1'b0;
        @(negedge clk);
        check("sqd_vld", {31'b0, res_vld}, 32'd0);
        check("sqd_hold", result, last_res);
        @(posedge clk); #1;
        squash_in = 1'b0;
        @(negedge clk);
        check("sqd_idle", {31'b0, stall_req}, 32'd0);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        req_vld = 1'b1;
        req_op  = 3'd0;
        op1     = 32'd9;
        op2     = 32'd9;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #3;
        rst_n   = 1'b0;
        req_vld = 1'b0;
        #1;
        check("mid_rst_stall", {31'b0, stall_req}, 32'd0);
        check("mid_rst_vld", {31'b0, res_vld}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32);
        run_op(3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 33, 32);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage. It owns one shared shift-add/restoring-subtract datapath and sequences it for all eight RV32M operations. It raises a stall request that the execute stage ORs into its internal stall generation, and it returns a one-cycle-valid result that the execute stage muxes onto its data output. Squash from downstream aborts an in-flight operation.

## Interface
- N_BITS, 32, operand/result width (must be even, ≥4)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_vld  in  1  X-stage instruction is valid and is M-extension
- req_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op1  in  N_BITS  rs1 operand (dividend / multiplicand)
- op2  in  N_BITS  rs2 operand (divisor / multiplier)
- squash_in  in  1  downstream squash; kills current request or operation
- stall_req  out  1  execute stage must hold its pipeline registers
- res_vld  out  1  result valid this cycle
- result  out  N_BITS  selected product half, quotient or remainder

## Operation
- States: IDLE, BUSY, DONE. Iteration counter is clog2(N_BITS)+1 bits wide.
- IDLE:
  - A request is accepted when req_vld && !squash_in.
  - On accept, latch the op, the operand magnitudes and both sign flags.
  - Signedness: op1 is signed for MULH, MULHSU, DIV and REM; op2 is signed for MULH, DIV and REM.
  - Divide by zero (op2==0, ops DIV/DIVU/REM/REMU): go directly to DONE. Quotient = all ones; remainder = op1 unmodified.
  - Signed overflow (DIV/REM with op1==1<<(N_BITS-1) and op2==all ones): go directly to DONE. Quotient = op1; remainder = 0.
  - Every other accepted request: go to BUSY with counter=0.
- BUSY, multiply:
  - 2*N_BITS-bit accumulator {hi,lo}; lo initialised to |op2|, hi to 0.
  - Each cycle: if lo[0], add |op1| to hi (with carry out); then shift the whole accumulator right by 1.
- BUSY, divide:
  - Restoring division.
  - Each cycle: shift {rem,quo} left by 1, then trial-subtract |op2| from rem. If there is no borrow, keep the difference and set quo[0]=1.
- BUSY ends after exactly N_BITS iterations and moves to DONE.
- DONE:
  - Apply sign fix: product is negated when the signs differ; quotient is negated when the signs differ; remainder takes the sign of op1.
  - result is the low product half (MUL), the high product half (MULH*), the quotient (DIV*) or the remainder (REM*).
  - Next state is always IDLE. req_vld is ignored in DONE; the same instruction is still presented that cycle.
- stall_req = (IDLE && req_vld && !squash_in) || BUSY. It is combinational and is 0 in DONE, so the X stage advances on the DONE edge.
- res_vld = DONE && !squash_in.
- result holds its last value when res_vld=0 and is 0 after reset.
- squash_in in BUSY: go to IDLE next edge, with no res_vld. squash_in in DONE: res_vld is suppressed and the state still returns to IDLE.

## Timing
- Reset (async assert): state IDLE, counter 0, stall_req 0, res_vld 0, result 0, accumulators 0. Reset mid-BUSY discards the operation.
- Normal op, with the accept edge as E0:
  - BUSY during cycles E0..E0+N_BITS-1.
  - DONE in cycle E0+N_BITS, with res_vld=1.
  - Total N_BITS+1 cycles with req_vld high; stall_req high for the first N_BITS of them.
- Special-case divide: DONE in the cycle after the accept edge, for a 2-cycle occupancy.
- Back-to-back requests: a new request can be accepted in the IDLE cycle after DONE. There is no acceptance in DONE itself.
- Sign fix and result mux are combinational from registered state in DONE. Inputs op1/op2/req_op are not used after acceptance.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> stall_req high 32 cycles; res_vld in cycle 33 with result 0xFFFFFFEB; next cycle stall_req=0, res_vld=0.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with res_vld one cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start a DIV, assert squash_in at iteration 10 -> IDLE next cycle, no res_vld. A MUL 3×4 issued right after -> 12 after 33 cycles.
- Assert rst_n=0 mid-BUSY -> all outputs 0 immediately. After release, the first request completes with normal latency.
